mux_ctrl_seq: RTL and testbench
===============================

Name: mux_ctrl_seq

Overview:
- Multicycle control sequencer for the 64-bit LEGv8 datapath.
- Accepts one 32-bit instruction at a time via a valid/ready handshake and decodes it.
- Drives the ALU operand-B select flag and the 64-bit extended immediate into the operand mux.
- Sequences the ALU op, memory access, register write-back and PC update through a 5-state FSM.

Parameters:
- DATA_W, 64, datapath width; immed output width.
- MEM_TIMEOUT, 16, max cycles waiting in MEM for mem_ready; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  fetch offers an instruction.
- instr_ready  output  1  sequencer can accept an instruction.
- instr  input  32  instruction word, sampled on handshake.
- zero  input  1  ALU zero flag, sampled in EXEC.
- mem_ready  input  1  data memory completes the access.
- alu_src  output  1  operand mux select: 0 = register data, 1 = immed.
- immed  output  DATA_W  extended immediate.
- alu_op  output  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B.
- reg_write  output  1  one-cycle write-back strobe.
- mem_read  output  1  load request.
- mem_write  output  1  store request.
- pc_write  output  1  one-cycle PC update strobe.
- pc_src  output  1  0 = PC+4, 1 = PC+immed; valid while pc_write is high.
- illegal  output  1  sticky; unknown opcode seen.
- mem_err  output  1  sticky; MEM timeout occurred.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; instr_ready=0 during reset; immed=0; sticky flags cleared. Reset mid-instruction abandons it with no strobes issued.
- IDLE: instr_ready=1. On instr_valid&instr_ready, latch instr -> DECODE.
- DECODE (1 cycle): compute alu_src, immed and alu_op, all registered. They become valid on EXEC entry and are held stable until return to IDLE.
  - ADD/SUB/AND/ORR (opcode[31:21] = 10001011000/11001011000/10001010000/10101010000): alu_src=0.
  - ADDI/SUBI ([31:22] = 1001000100/1101000100): alu_src=1; immed = zero-extended instr[21:10].
  - LDUR/STUR ([31:21] = 11111000010/11111000000): alu_src=1, ADD; immed = sign-extended instr[20:12].
  - CBZ ([31:24] = 10110100): alu_src=0, pass-B; immed = sign-extended instr[23:5]<<2.
  - B ([31:26] = 000101): immed = sign-extended instr[25:0]<<2.
  - Any other opcode: set illegal; pc_write=1, pc_src=0 on the transition cycle; -> IDLE.
- EXEC (1 cycle):
  - R/I-type -> WB.
  - LDUR/STUR -> MEM.
  - CBZ: pc_write=1, pc_src=zero; -> IDLE.
  - B: pc_write=1, pc_src=1; -> IDLE.
- MEM:
  - mem_read (LDUR) or mem_write (STUR) is held high until mem_ready is sampled high, then deasserts.
  - On mem_ready: LDUR -> WB; STUR -> pc_write=1, pc_src=0 -> IDLE.
  - mem_ready already high on MEM entry completes in 1 cycle.
  - The wait counter resets on MEM entry. If MEM_TIMEOUT>0 and no mem_ready after MEM_TIMEOUT cycles: drop the request, set mem_err, pulse pc_write (pc_src=0), -> IDLE.
- WB (1 cycle): reg_write=1, pc_write=1, pc_src=0; -> IDLE.
- Latency, accept to next instr_ready:
  - R/I-type: 4 cycles.
  - B/CBZ: 3 cycles.
  - LDUR, zero-wait: 5 cycles.
  - STUR, zero-wait: 4 cycles.
  - Illegal opcode: 2 cycles.
- Strobes (reg_write, pc_write) are exactly one cycle per instruction. They never overlap mem_read/mem_write.
- instr_valid is ignored outside IDLE. instr is not re-sampled.

Optional Feature:
- PERF_CNT_EN defined: adds outputs cyc_cnt[31:0] and ret_cnt[31:0], both reset to 0, wrapping.
  - cyc_cnt increments every cycle when state != IDLE.
  - ret_cnt increments on every pc_write pulse, excluding illegal opcodes and mem_err aborts.
- PERF_CNT_EN undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- ADDI with instr[21:10]=0x005 -> from EXEC: alu_src=1, immed=64'h5, alu_op=0010; reg_write pulse in WB; instr_ready returns 4 cycles after accept.
- LDUR with DT=-8 (instr[20:12]=9'h1F8), mem_ready delayed 3 cycles -> immed=64'hFFFF_FFFF_FFFF_FFF8; mem_read high for exactly 4 MEM cycles; then reg_write pulse.
- CBZ with instr[23:5]=19'h7FFFF and zero=1 -> immed=64'hFFFF_FFFF_FFFF_FFFC; pc_write=1, pc_src=1. Repeat with zero=0 -> pc_src=0.
- Opcode 0x000 -> illegal=1 and stays high; pc_write pulse; next valid ADD executes normally.
- STUR with mem_ready held 0 and MEM_TIMEOUT=16 -> mem_write high 16 cycles, then mem_err=1 and return to IDLE.
- rst_n asserted during MEM of a LDUR -> mem_read=0 immediately; no reg_write; state=IDLE after release.

Source files
------------

// File: rtl/mux_ctrl_seq.sv
// Multicycle control sequencer for the 64-bit LEGv8 datapath: decodes one instruction at a time
// and drives the operand mux, ALU op, memory access, write-back and PC-update strobes.
// Optional `define PERF_CNT_EN adds cyc_cnt/ret_cnt performance counters.
module mux_ctrl_seq #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              alu_src,
  output logic [DATA_W-1:0] immed,
  output logic [3:0]        alu_op,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              pc_write,
  output logic              pc_src,
  output logic              illegal,
  output logic              mem_err
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       ret_cnt
`endif
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 2);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOrr  = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpPass = 4'b0111;

  typedef enum logic [2:0] {StIdle, StDecode, StExec, StMem, StWb} state_e;
  typedef enum logic [2:0] {ClsR, ClsI, ClsLd, ClsSt, ClsCbz, ClsB, ClsBad} cls_e;

  state_e            state_q, state_d;
  cls_e              cls_q, dec_cls;
  logic [31:0]       instr_q;
  logic              alu_src_q, dec_alu_src;
  logic [DATA_W-1:0] immed_q, dec_immed;
  logic [3:0]        alu_op_q, dec_alu_op;
  logic              illegal_q, mem_err_q;
  logic [CntW-1:0]   wait_q, wait_d;
  logic              st_done_q, st_done_d;
  logic              pc_now, set_illegal, set_mem_err, timeout;

  // Decode of the latched instruction word; only consumed while in DECODE.
  always_comb begin
    dec_cls     = ClsBad;
    dec_alu_src = 1'b0;
    dec_immed   = '0;
    dec_alu_op  = OpAdd;
    if (instr_q[31:21] == 11'b10001011000) begin
      dec_cls    = ClsR;
      dec_alu_op = OpAdd;
    end else if (instr_q[31:21] == 11'b11001011000) begin
      dec_cls    = ClsR;
      dec_alu_op = OpSub;
    end else if (instr_q[31:21] == 11'b10001010000) begin
      dec_cls    = ClsR;
      dec_alu_op = OpAnd;
    end else if (instr_q[31:21] == 11'b10101010000) begin
      dec_cls    = ClsR;
      dec_alu_op = OpOrr;
    end else if (instr_q[31:22] == 10'b1001000100 || instr_q[31:22] == 10'b1101000100) begin
      dec_cls     = ClsI;
      dec_alu_src = 1'b1;
      dec_immed   = {{(DATA_W-12){1'b0}}, instr_q[21:10]};
      dec_alu_op  = instr_q[30] ? OpSub : OpAdd;
    end else if (instr_q[31:21] == 11'b11111000010 || instr_q[31:21] == 11'b11111000000) begin
      dec_cls     = instr_q[22] ? ClsLd : ClsSt;
      dec_alu_src = 1'b1;
      dec_immed   = {{(DATA_W-9){instr_q[20]}}, instr_q[20:12]};
      dec_alu_op  = OpAdd;
    end else if (instr_q[31:24] == 8'b10110100) begin
      dec_cls    = ClsCbz;
      dec_immed  = {{(DATA_W-21){instr_q[23]}}, instr_q[23:5], 2'b00};
      dec_alu_op = OpPass;
    end else if (instr_q[31:26] == 6'b000101) begin
      dec_cls   = ClsB;
      dec_immed = {{(DATA_W-28){instr_q[25]}}, instr_q[25:0], 2'b00};
    end
  end

  assign timeout = (MEM_TIMEOUT != 0) && (state_q == StMem) &&
                   (wait_q == CntW'(MEM_TIMEOUT));
  assign instr_ready = rst_n && (state_q == StIdle);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    st_done_d   = 1'b0;
    pc_now      = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    set_illegal = 1'b0;
    set_mem_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (instr_valid && instr_ready) state_d = StDecode;
      end
      StDecode: begin
        if (dec_cls == ClsBad) begin
          pc_now      = 1'b1;
          set_illegal = 1'b1;
          state_d     = StIdle;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        unique case (cls_q)
          ClsR, ClsI: state_d = StWb;
          ClsLd, ClsSt: begin
            wait_d  = '0;
            state_d = StMem;
          end
          ClsCbz: begin
            pc_now  = 1'b1;
            pc_src  = zero;
            state_d = StIdle;
          end
          ClsB: begin
            pc_now  = 1'b1;
            pc_src  = 1'b1;
            state_d = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
      StMem: begin
        if (timeout) begin
          pc_now      = 1'b1;
          set_mem_err = 1'b1;
          state_d     = StIdle;
        end else begin
          mem_read  = (cls_q == ClsLd);
          mem_write = (cls_q == ClsSt);
          if (MEM_TIMEOUT != 0) wait_d = wait_q + 1'b1;
          if (mem_ready) begin
            // Store's PC update is issued the following cycle so it never overlaps mem_write.
            if (cls_q == ClsLd) begin
              state_d = StWb;
            end else begin
              st_done_d = 1'b1;
              state_d   = StIdle;
            end
          end
        end
      end
      StWb: begin
        reg_write = 1'b1;
        pc_now    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign pc_write = pc_now | st_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cls_q     <= ClsBad;
      instr_q   <= '0;
      alu_src_q <= 1'b0;
      immed_q   <= '0;
      alu_op_q  <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
      wait_q    <= '0;
      st_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      st_done_q <= st_done_d;
      if (instr_valid && instr_ready) instr_q <= instr;
      if (state_q == StDecode && dec_cls != ClsBad) begin
        cls_q     <= dec_cls;
        alu_src_q <= dec_alu_src;
        immed_q   <= dec_immed;
        alu_op_q  <= dec_alu_op;
      end
      if (set_illegal) illegal_q <= 1'b1;
      if (set_mem_err) mem_err_q <= 1'b1;
    end
  end

  assign alu_src = alu_src_q;
  assign immed   = immed_q;
  assign alu_op  = alu_op_q;
  assign illegal = illegal_q;
  assign mem_err = mem_err_q;

`ifdef PERF_CNT_EN
  // Retirements exclude illegal-opcode skips (DECODE) and MEM timeout aborts.
  logic retire;
  assign retire = pc_write && (state_q != StDecode) && !timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (state_q != StIdle) cyc_cnt <= cyc_cnt + 32'd1;
      if (retire) ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_ctrl_seq.sv
// Directed self-checking bench for mux_ctrl_seq (default MEM_TIMEOUT=16).
module tb_mux_ctrl_seq;

  localparam logic [31:0] IAddi = {10'b1001000100, 12'h005, 10'd0};
  localparam logic [31:0] ILdur = {11'b11111000010, 9'h1F8, 12'd0};
  localparam logic [31:0] IStur = {11'b11111000000, 9'h010, 12'd0};
  localparam logic [31:0] ICbz  = {8'b10110100, 19'h7FFFF, 5'd0};
  localparam logic [31:0] IB    = {6'b000101, 26'h1};
  localparam logic [31:0] IAdd  = {11'b10001011000, 21'd0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        alu_src;
  logic [63:0] immed;
  logic [3:0]  alu_op;
  logic        reg_write, mem_read, mem_write, pc_write, pc_src, illegal, mem_err;
`ifdef PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  int tests = 0;
  int failed = 0;

  mux_ctrl_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .alu_src     (alu_src),
    .immed       (immed),
    .alu_op      (alu_op),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .illegal     (illegal),
    .mem_err     (mem_err)
`ifdef PERF_CNT_EN
    ,
    .cyc_cnt     (cyc_cnt),
    .ret_cnt     (ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Waits (bounded) for instr_ready, then performs one handshake; returns in DECODE.
  task automatic accept(input logic [31:0] w);
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin
      step();
      n++;
    end
    chk("accept_ready", instr_ready, 1'b1);
    instr       = w;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instr       = 32'hFFFF_FFFF;
  endtask

  initial begin
    int nr, nw, wb_at, pw_at, ov, rw;

    // Reset state
    #1;
    chk("rst_ready", instr_ready, 1'b0);
    chk("rst_strobes", {reg_write, mem_read, mem_write, pc_write, pc_src}, 5'b0);
    chk("rst_immed", immed, 64'h0);
    chk("rst_sticky", {illegal, mem_err}, 2'b0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("idle_ready", instr_ready, 1'b1);

    // ADDI #5: 4 cycles accept to ready
    accept(IAddi);
    chk("addi_dec_ready", instr_ready, 1'b0);
    step();
    chk("addi_exec_src", alu_src, 1'b1);
    chk("addi_exec_immed", immed, 64'h5);
    chk("addi_exec_op", alu_op, 4'b0010);
    chk("addi_exec_rw", reg_write, 1'b0);
    step();
    chk("addi_wb_strobes", {reg_write, pc_write, pc_src}, 3'b110);
    chk("addi_wb_hold", alu_src, 1'b1);
    step();
    chk("addi_ret_ready", instr_ready, 1'b1);
    chk("addi_ret_rw", reg_write, 1'b0);

    // LDUR DT=-8, mem_ready on 4th MEM cycle
    accept(ILdur);
    step();
    chk("ldur_immed", immed, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("ldur_exec_rd", mem_read, 1'b0);
    step();
    nr = 0; wb_at = -1; ov = 0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = (i == 3);
      #1;
      if (mem_read) nr++;
      if (reg_write) wb_at = i;
      if (mem_read && (reg_write || pc_write)) ov++;
      step();
    end
    mem_ready = 1'b0;
    chk("ldur_rd_cycles", nr, 4);
    chk("ldur_wb_cycle", wb_at, 4);
    chk("ldur_overlap", ov, 0);

    // CBZ, zero=1 then zero=0
    accept(ICbz);
    step();
    zero = 1'b1;
    #1;
    chk("cbz_immed", immed, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("cbz_op_src", {alu_op, alu_src}, 5'b01110);
    chk("cbz_taken", {pc_write, pc_src}, 2'b11);
    step();
    chk("cbz_ret", {instr_ready, pc_write}, 2'b10);
    accept(ICbz);
    step();
    zero = 1'b0;
    #1;
    chk("cbz_not_taken", {pc_write, pc_src}, 2'b10);
    step();

    // B +1 word
    accept(IB);
    step();
    chk("b_immed", immed, 64'h4);
    chk("b_pc", {pc_write, pc_src}, 2'b11);
    step();
    chk("b_ret_ready", instr_ready, 1'b1);

    // Illegal opcode 0, then ADD
    accept(32'h0);
    chk("ill_dec_pc", {pc_write, pc_src}, 2'b10);
    chk("ill_not_yet", illegal, 1'b0);
    step();
    chk("ill_set", illegal, 1'b1);
    chk("ill_ret", {instr_ready, pc_write}, 2'b10);
    accept(IAdd);
    step();
    chk("add_exec", {alu_src, alu_op}, 5'b00010);
    step();
    chk("add_wb", {reg_write, pc_write}, 2'b11);
    chk("ill_sticky", illegal, 1'b1);
    step();

    // STUR with zero-wait memory
    accept(IStur);
    step();
    chk("stur_immed", immed, 64'h10);
    step();
    mem_ready = 1'b1;
    #1;
    chk("stur_mem", {mem_write, pc_write}, 2'b10);
    step();
    mem_ready = 1'b0;
    chk("stur_done", {instr_ready, pc_write, pc_src, mem_write}, 4'b1100);
    step();
    chk("stur_pulse_end", pc_write, 1'b0);

    // STUR timeout
    accept(IStur);
    step();
    step();
    nw = 0; pw_at = -1; ov = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (mem_write) nw++;
      if (pc_write && pw_at < 0) pw_at = i;
      if (mem_write && pc_write) ov++;
      step();
    end
    chk("to_wr_cycles", nw, 16);
    chk("to_pc_cycle", pw_at, 16);
    chk("to_overlap", ov, 0);
    chk("to_mem_err", {mem_err, instr_ready}, 2'b11);

    // Reset during LDUR MEM
    accept(ILdur);
    step();
    step();
    chk("rmem_rd", mem_read, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rmem_rd_drop", mem_read, 1'b0);
    chk("rmem_ready_low", instr_ready, 1'b0);
    chk("rmem_sticky_clr", {illegal, mem_err}, 2'b00);
    step();
    rst_n = 1'b1;
    #1;
    chk("rmem_idle", instr_ready, 1'b1);
    rw = 0;
    for (int i = 0; i < 6; i++) begin
      if (reg_write || pc_write) rw++;
      step();
    end
    chk("rmem_no_strobe", rw, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
